mult_share_scheduler: RTL and testbench
=======================================

# mult_share_scheduler

Round-robin scheduler that time-shares one external `multiplier35x35` (35×35 → 70-bit, combinational, multicycle) among `N_REQ` requesters. These are typically several slow IIR filter channels that each need one multiply-accumulate at a time. The block latches the winner's operands, waits the multiplier settling time, adds the accumulate term, and returns the result with a one-cycle valid strobe to the winner. It sits between the filter-channel state machines and the single multiplier instance, replacing per-channel multipliers.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters (2..8).
- `MULT_WAIT`, 4: cycles the multiplier output needs to settle after operands change (≥1).

Ports:
- `clk_in`, in, 1: clock.
- `rst_n_in`, in, 1: reset, asynchronous and active-low.
- `req_in`, in, N_REQ: per-requester request level.
- `a_in`, in, N_REQ×35: packed signed operand A, slice k = requester k.
- `b_in`, in, N_REQ×35: packed signed operand B.
- `c_in`, in, N_REQ×70: packed signed accumulate term.
- `grant_out`, out, N_REQ: one-hot, one-cycle pulse; the operands have been latched.
- `valid_out`, out, N_REQ: one-hot, one-cycle pulse; `p_out` holds that requester's result.
- `p_out`, out, 70: signed result A·B + C; held until the next valid.
- `busy_out`, out, 1: high while an operation is in flight.
- `mult_a_out`, out, 35: drives the multiplier `a` input (registered).
- `mult_b_out`, out, 35: drives the multiplier `b` input (registered).
- `mult_p_in`, in, 70: multiplier product.

## Operation
- State machine: IDLE, WAIT, DONE. Reset forces IDLE.
- **IDLE:** if any `req_in` bit is set, the round-robin pick selects a winner.
  - Latch the winner's A into `mult_a_out`, B into `mult_b_out`, C into an internal register, and the winner index.
  - Pulse `grant_out[winner]`, clear the counter, go to WAIT.
  - If no request, stay in IDLE.
- **WAIT:** increment the counter each cycle. When counter == MULT_WAIT−1, register `p_out` = `mult_p_in` + C (70-bit, wraps mod 2^70) and go to DONE.
- **DONE:**
  - Pulse `valid_out[winner]` and set the priority pointer = winner.
  - Re-arbitrate in the same cycle. A winner latches exactly as in IDLE and goes to WAIT; otherwise go to IDLE.
- **Round-robin:** search starts at pointer+1 modulo N_REQ. A lone requester wins every time.
- **Request rule:** a requester keeps `req_in` and its operands stable until it sees its grant.
  - It drops `req_in` in the cycle after the grant unless it has another operation.
  - `req_in` is sampled only in IDLE and DONE. Operands of non-granted requesters are ignored.
  - A request that drops before its grant is simply not served.
- **Simultaneous events:** in DONE, the requester being validated can be regranted if it is the only request. Its `grant_out` and `valid_out` are then high in the same cycle.
- **Reset mid-operation:** the operation is discarded and no valid is issued. The pointer is set to N_REQ−1, so requester 0 has first priority.
- **Reset values:**
  - `grant_out`, `valid_out`: 0.
  - `p_out`: 0.
  - `busy_out`: 0.
  - `mult_a_out`, `mult_b_out`: 0.
  - Counter: 0.
- `busy_out` = (state != IDLE).

## Timing
- Cycle 0: IDLE, request sampled.
- Cycle 1: WAIT, counter 0, `grant_out` high, mult operands valid.
- Cycle MULT_WAIT: last WAIT cycle; `mult_p_in` is sampled at its end.
- Cycle MULT_WAIT+1: DONE, `valid_out` and `p_out` valid.
- Request-to-valid latency: MULT_WAIT+1 cycles.
- Back-to-back throughput: one operation per MULT_WAIT+1 cycles. With MULT_WAIT=4: grant at cycle 1, valid at 5, next grant at 6.
- `mult_a_out` and `mult_b_out` are constant from grant through DONE. The multiplier path is therefore a MULT_WAIT-cycle multicycle path, constrained accordingly.

## Structure
- Shared package holds:
  - operand width 35 and product width 70;
  - the state encoding (IDLE/WAIT/DONE);
  - the pointer-width function clog2(N_REQ).
- Sub-module `rr_pick`: combinational round-robin picker.
  - Inputs: request vector and pointer.
  - Outputs: one-hot grant, index, and any-request flag.
- The multiplier stays outside this block; it is instantiated by the parent.

## Test plan
- Reset, then requester 2 alone with A=3, B=−5, C=100, MULT_WAIT=4 → `grant_out`=0b0100 at cycle 1; `valid_out`=0b0100 and `p_out`=85 at cycle 5; `busy_out` low at cycle 6.
- All four requesting continuously after reset → grant order 0,1,2,3,0; grants spaced 5 cycles apart; each `p_out` matches its own operands.
- Requester 1 alone, holding `req_in` after its valid → regranted in the DONE cycle, with `grant_out` and `valid_out` both 0b0010 that cycle.
- A=−2^34, B=−2^34, C=2^69−1 → `p_out` equals the 70-bit wrapped sum; no X, no saturation.
- `rst_n_in` asserted at cycle 3 of an operation → all outputs 0 immediately, no valid; the next request from requester 0 is granted first.
- Requester 3 drops `req_in` while requester 0 is in WAIT → requester 3 is never granted and no valid is produced for it.

Source files
------------

// File: rtl/mult_share_scheduler_pkg.sv
// Shared widths, FSM encoding and sizing helper for the shared-multiplier scheduler.
package mult_share_scheduler_pkg;

   localparam int OP_W   = 35;
   localparam int PROD_W = 70;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Ceiling log2, never below 1 so a vector sized by it always exists.
   function automatic int clog2(input int n);
      int w;
      w = 0;
      while ((1 << w) < n) w++;
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/mult_share_scheduler_rr_pick.sv
// Combinational round-robin picker: first set request strictly after ptr, wrapping.
module rr_pick
   import mult_share_scheduler_pkg::*;
#(
   parameter  int N_REQ = 4,
   localparam int PTR_W = clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N_REQ-1:0] gnt,
   output logic [PTR_W-1:0] idx,
   output logic             any
);

   assign any = |req;

   // Walk from the farthest candidate back to ptr+1 so the nearest one is written last.
   always_comb begin
      int               k;
      logic [PTR_W-1:0] k_idx;
      // NOTE: every always_comb output gets a default first; a missed path would infer a latch.
      gnt   = '0;
      idx   = '0;
      k     = 0;
      k_idx = '0;
      for (int i = N_REQ; i >= 1; i--) begin
         k     = (int'(ptr) + i) % N_REQ;
         k_idx = PTR_W'(k);
         if (req[k_idx]) begin
            gnt        = '0;
            gnt[k_idx] = 1'b1;
            idx        = k_idx;
         end
      end
   end

endmodule

// File: rtl/mult_share_scheduler.sv
// Time-shares one external multicycle 35x35 multiplier among N_REQ requesters,
// returning A*B + C to each winner in round-robin order.
module mult_share_scheduler
   import mult_share_scheduler_pkg::*;
#(
   parameter int N_REQ     = 4,
   parameter int MULT_WAIT = 4
) (
   input  logic                    clk_in,
   input  logic                    rst_n_in,
   input  logic [N_REQ-1:0]        req_in,
   input  logic [N_REQ*OP_W-1:0]   a_in,
   input  logic [N_REQ*OP_W-1:0]   b_in,
   input  logic [N_REQ*PROD_W-1:0] c_in,
   output logic [N_REQ-1:0]        grant_out,
   output logic [N_REQ-1:0]        valid_out,
   output logic [PROD_W-1:0]       p_out,
   output logic                    busy_out,
   output logic [OP_W-1:0]         mult_a_out,
   output logic [OP_W-1:0]         mult_b_out,
   input  logic [PROD_W-1:0]       mult_p_in
);

   localparam int               PTR_W    = clog2(N_REQ);
   localparam int               CNT_W    = clog2(MULT_WAIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MULT_WAIT - 1);
   localparam logic [PTR_W-1:0] PTR_RST  = PTR_W'(N_REQ - 1);

   state_t              state;
   state_t              state_d;
   logic [CNT_W-1:0]    cnt;
   logic [PTR_W-1:0]    ptr;
   logic [PTR_W-1:0]    win_idx;
   logic [PTR_W-1:0]    pick_ptr;
   logic [PTR_W-1:0]    pick_idx;
   logic [N_REQ-1:0]    pick_gnt;
   logic                pick_any;
   logic [PROD_W-1:0]   c_reg;
   logic                load;
   logic                finish;

   // In DONE the pointer moves to the current winner in the same cycle it re-arbitrates.
   assign pick_ptr = (state == ST_DONE) ? win_idx : ptr;

   rr_pick #(.N_REQ(N_REQ)) u_pick (
      .req (req_in),
      .ptr (pick_ptr),
      .gnt (pick_gnt),
      .idx (pick_idx),
      .any (pick_any)
   );

   always_comb begin
      state_d = state;
      load    = 1'b0;
      finish  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (pick_any) begin
               load    = 1'b1;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (cnt == CNT_LAST) begin
               finish  = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (pick_any) begin
               load    = 1'b1;
               state_d = ST_WAIT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) state <= ST_IDLE;
      else           state <= state_d;
   end

   // NOTE: every register here is plain control/datapath state, so all of it is reset;
   // an in-flight operation is simply dropped.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         cnt        <= '0;
         ptr        <= PTR_RST;
         win_idx    <= '0;
         c_reg      <= '0;
         mult_a_out <= '0;
         mult_b_out <= '0;
         p_out      <= '0;
         grant_out  <= '0;
         valid_out  <= '0;
      end else begin
         grant_out <= '0;
         valid_out <= '0;

         if (load) begin
            mult_a_out <= a_in[pick_idx*OP_W +: OP_W];
            mult_b_out <= b_in[pick_idx*OP_W +: OP_W];
            c_reg      <= c_in[pick_idx*PROD_W +: PROD_W];
            win_idx    <= pick_idx;
            grant_out  <= pick_gnt;
            cnt        <= '0;
         end else if (state == ST_WAIT) begin
            cnt <= cnt + CNT_W'(1);
         end

         // Product has settled by the end of the last WAIT cycle; the add wraps mod 2^70.
         if (finish) begin
            p_out     <= mult_p_in + c_reg;
            valid_out <= N_REQ'(1) << win_idx;
         end

         if (state == ST_DONE) ptr <= win_idx;
      end
   end

   assign busy_out = (state != ST_IDLE);

endmodule

// File: tb/tb_mult_share_scheduler.sv
// Scoreboard bench: requester agents feed queued operations, a list-rotation model
// predicts service order and results, and a monitor checks every grant and valid.
module tb_mult_share_scheduler;
   import mult_share_scheduler_pkg::*;

   localparam int N  = 4;
   localparam int MW = 4;

   typedef struct {
      logic [34:0] a;
      logic [34:0] b;
      logic [69:0] c;
   } op_t;

   typedef struct {
      int          idx;
      logic [69:0] p;
   } res_t;

   logic              clk_in   = 1'b0;
   logic              rst_n_in = 1'b0;
   logic [N-1:0]      req_in   = '0;
   logic [N*35-1:0]   a_in     = '0;
   logic [N*35-1:0]   b_in     = '0;
   logic [N*70-1:0]   c_in     = '0;
   logic [N-1:0]      grant_out;
   logic [N-1:0]      valid_out;
   logic [69:0]       p_out;
   logic              busy_out;
   logic [34:0]       mult_a_out;
   logic [34:0]       mult_b_out;
   logic [69:0]       mult_p_in;

   op_t   req_q[N][$];
   int    exp_g_q[$];
   res_t  exp_r_q[$];
   int    errors = 0;
   int    checks = 0;
   int    cyc = 0;
   int    model_ptr = N - 1;
   int    last_g = -1;
   int    grant_cyc[N];
   int    grant_count = 0;
   int    valid_count = 0;
   int    last_valid_cyc = 0;
   int    stable_cnt = 0;
   logic [34:0] seen_a = '0;
   logic [34:0] seen_b = '0;

   mult_share_scheduler #(.N_REQ(N), .MULT_WAIT(MW)) dut (
      .clk_in     (clk_in),
      .rst_n_in   (rst_n_in),
      .req_in     (req_in),
      .a_in       (a_in),
      .b_in       (b_in),
      .c_in       (c_in),
      .grant_out  (grant_out),
      .valid_out  (valid_out),
      .p_out      (p_out),
      .busy_out   (busy_out),
      .mult_a_out (mult_a_out),
      .mult_b_out (mult_b_out),
      .mult_p_in  (mult_p_in)
   );

   always #5 clk_in = ~clk_in;
   always @(posedge clk_in) cyc++;

   function automatic logic [69:0] prod70(input logic [34:0] a, input logic [34:0] b);
      logic signed [69:0] ea;
      logic signed [69:0] eb;
      ea = {{35{a[34]}}, a};
      eb = {{35{b[34]}}, b};
      return ea * eb;
   endfunction

   // External multiplier: garbage until its operands have been stable for MW cycles.
   always @(negedge clk_in) begin
      if (mult_a_out != seen_a || mult_b_out != seen_b) stable_cnt = 1;
      else stable_cnt++;
      seen_a = mult_a_out;
      seen_b = mult_b_out;
   end
   assign mult_p_in = (stable_cnt >= MW) ? prod70(mult_a_out, mult_b_out)
                                         : ~prod70(mult_a_out, mult_b_out);

   task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int onehot_idx(input logic [N-1:0] v);
      int r;
      r = -1;
      for (int i = 0; i < N; i++) if (v[i]) r = i;
      return r;
   endfunction

   // Requester agents: hold request and operands of the head op until granted.
   always @(negedge clk_in) begin
      if (rst_n_in)
         for (int k = 0; k < N; k++)
            if (grant_out[k] && req_q[k].size() > 0) void'(req_q[k].pop_front());
      for (int k = 0; k < N; k++) begin
         if (req_q[k].size() > 0) begin
            req_in[k]           = 1'b1;
            a_in[k*35 +: 35]    = req_q[k][0].a;
            b_in[k*35 +: 35]    = req_q[k][0].b;
            c_in[k*70 +: 70]    = req_q[k][0].c;
         end else begin
            req_in[k]           = 1'b0;
            a_in[k*35 +: 35]    = 35'({$urandom(), $urandom()});
            b_in[k*35 +: 35]    = 35'({$urandom(), $urandom()});
            c_in[k*70 +: 70]    = 70'({$urandom(), $urandom(), $urandom()});
         end
      end
   end

   // Monitor: pops the scoreboard on every grant and valid.
   always @(negedge clk_in) begin
      int   gi;
      int   vi;
      res_t r;
      if (rst_n_in) begin
         if (grant_out != '0) begin
            gi = onehot_idx(grant_out);
            check("grant_onehot", 70'($onehot(grant_out)), 70'(1));
            if (exp_g_q.size() == 0) check("grant_unexpected", 70'(gi), 70'(-1));
            else check("grant_order", 70'(gi), 70'(exp_g_q.pop_front()));
            if (last_g >= 0) check("grant_spacing", 70'(cyc - last_g), 70'(MW + 1));
            last_g = cyc;
            if (gi >= 0) grant_cyc[gi] = cyc;
            grant_count++;
         end
         if (valid_out != '0) begin
            vi = onehot_idx(valid_out);
            check("valid_onehot", 70'($onehot(valid_out)), 70'(1));
            if (exp_r_q.size() == 0) begin
               check("valid_unexpected", 70'(vi), 70'(-1));
            end else begin
               r = exp_r_q.pop_front();
               check("valid_order", 70'(vi), 70'(r.idx));
               check("valid_p", p_out, r.p);
            end
            if (vi >= 0) check("valid_latency", 70'(cyc - grant_cyc[vi]), 70'(MW));
            last_valid_cyc = cyc;
            valid_count++;
         end
      end
   end

   task automatic push_op(input int k, input logic [34:0] a, input logic [34:0] b,
                          input logic [69:0] c);
      op_t o;
      o.a = a;
      o.b = b;
      o.c = c;
      req_q[k].push_back(o);
   endtask

   task automatic push_random(input int k);
      push_op(k, 35'({$urandom(), $urandom()}), 35'({$urandom(), $urandom()}),
              70'({$urandom(), $urandom(), $urandom()}));
   endtask

   // Service order: rotate from the last served requester to the next one with work left.
   task automatic commit_phase();
      int   left[N];
      int   pos[N];
      int   total;
      int   p;
      res_t r;
      total = 0;
      for (int k = 0; k < N; k++) begin
         left[k] = req_q[k].size();
         pos[k]  = 0;
         total  += left[k];
      end
      p = model_ptr;
      while (total > 0) begin
         do p = (p + 1) % N; while (left[p] == 0);
         exp_g_q.push_back(p);
         r.idx = p;
         r.p   = prod70(req_q[p][pos[p]].a, req_q[p][pos[p]].b) + req_q[p][pos[p]].c;
         exp_r_q.push_back(r);
         pos[p]++;
         left[p]--;
         total--;
      end
      model_ptr = p;
      last_g    = -1;
   endtask

   task automatic wait_done(input int budget);
      for (int t = 0; t < budget; t++) begin
         @(negedge clk_in);
         #2;
         if (exp_g_q.size() == 0 && exp_r_q.size() == 0 && !busy_out) return;
      end
      check("phase_timeout", 70'(exp_r_q.size()), 70'(0));
   endtask

   task automatic wait_grant(input int budget);
      int g0;
      g0 = grant_count;
      for (int t = 0; t < budget; t++) begin
         @(negedge clk_in);
         #2;
         if (grant_count != g0) return;
      end
      check("grant_timeout", 70'(grant_count - g0), 70'(1));
   endtask

   task automatic flush_all();
      for (int k = 0; k < N; k++) req_q[k].delete();
      exp_g_q.delete();
      exp_r_q.delete();
      model_ptr = N - 1;
      last_g    = -1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_grant"}, 70'(grant_out), 70'(0));
      check({tag, "_valid"}, 70'(valid_out), 70'(0));
      check({tag, "_p"},     p_out,          70'(0));
      check({tag, "_busy"},  70'(busy_out),  70'(0));
      check({tag, "_ma"},    70'(mult_a_out), 70'(0));
      check({tag, "_mb"},    70'(mult_b_out), 70'(0));
   endtask

   task automatic do_reset();
      @(negedge clk_in);
      #2;
      rst_n_in = 1'b0;
      flush_all();
      repeat (3) @(posedge clk_in);
      @(negedge clk_in);
      rst_n_in = 1'b1;
   endtask

   initial begin
      int load_cyc;
      int g0;
      int nops;
      int any_ops;

      #2;
      check_all_zero("reset");
      repeat (3) @(posedge clk_in);
      @(negedge clk_in);
      rst_n_in = 1'b1;

      // Requester 2 alone: 3 * -5 + 100 = 85.
      @(posedge clk_in);
      #1;
      push_op(2, 35'(3), 35'(-5), 70'(100));
      load_cyc = cyc;
      commit_phase();
      wait_done(40);
      check("t1_grant_cycle", 70'(grant_cyc[2]), 70'(load_cyc + 1));
      check("t1_valid_cycle", 70'(last_valid_cyc), 70'(load_cyc + 1 + MW));
      check("t1_p", p_out, 70'(85));
      check("t1_idle_cycle", 70'(cyc), 70'(last_valid_cyc + 1));
      check("t1_busy", 70'(busy_out), 70'(0));

      // All four requesting continuously from reset: order 0,1,2,3,0,...
      do_reset();
      @(posedge clk_in);
      #1;
      for (int k = 0; k < N; k++) begin
         push_random(k);
         push_random(k);
      end
      commit_phase();
      wait_done(80);

      // Requester 1 alone with two queued operations: back-to-back regrant.
      @(posedge clk_in);
      #1;
      push_random(1);
      push_random(1);
      commit_phase();
      wait_done(40);

      // Extreme operands: (-2^34)^2 + (2^69-1) wraps to 2'b10 followed by 68 ones.
      @(posedge clk_in);
      #1;
      push_op(0, {1'b1, 34'd0}, {1'b1, 34'd0}, {1'b0, {69{1'b1}}});
      commit_phase();
      wait_done(40);
      check("t4_wrap", p_out, {2'b10, {68{1'b1}}});
      @(posedge clk_in);
      #1;
      push_op(3, {1'b1, 34'd0}, {1'b0, {34{1'b1}}}, {1'b1, 69'd0});
      commit_phase();
      wait_done(40);

      // Reset at cycle 3 of an operation: everything clears, no valid, requester 0 first after.
      @(posedge clk_in);
      #1;
      push_random(2);
      commit_phase();
      wait_grant(20);
      repeat (2) @(negedge clk_in);
      #2;
      rst_n_in = 1'b0;
      #1;
      check_all_zero("midrst");
      flush_all();
      g0 = valid_count;
      for (int t = 0; t < 3; t++) begin
         @(negedge clk_in);
         check("midrst_no_valid", 70'(valid_out), 70'(0));
      end
      rst_n_in = 1'b1;
      @(posedge clk_in);
      #1;
      push_random(2);
      push_random(0);
      commit_phase();
      wait_done(40);

      // Requester 3 raises and drops its request while requester 0 is in WAIT.
      @(posedge clk_in);
      #1;
      push_random(0);
      commit_phase();
      g0 = grant_count;
      wait_grant(20);
      @(posedge clk_in);
      #1;
      push_random(3);
      @(posedge clk_in);
      #1;
      req_q[3].delete();
      wait_done(40);
      check("t6_grants", 70'(grant_count - g0), 70'(1));

      // Randomised phases over random subsets of requesters.
      for (int round = 0; round < 25; round++) begin
         @(posedge clk_in);
         #1;
         any_ops = 0;
         for (int k = 0; k < N; k++) begin
            nops = $urandom_range(0, 3);
            for (int j = 0; j < nops; j++) push_random(k);
            any_ops += nops;
         end
         commit_phase();
         if (any_ops > 0) wait_done(any_ops * (MW + 1) + 20);
      end

      check("final_queues", 70'(exp_g_q.size() + exp_r_q.size()), 70'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
